// File: rtl/defuse_game_core.sv
// rtl/defuse_game_core.sv - bomb-defuse puzzle engine: LFSR puzzle draw, answer judge, stage/strike/timer tracking
// Screens and main symbol are sliced from the LFSR value present in LOAD.
module defuse_game_core #(
    parameter int          NUM_SCREENS = 4,
    parameter int          SYM_W       = 2,
    parameter int          STAGES      = 3,
    parameter int          MAX_STRIKES = 3,
    parameter int          TIME_W      = 8,
    parameter int          TIME_INIT   = 60,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         tick,
    input  logic                         start_btn,
    input  logic                         set_btn,
    input  logic [NUM_SCREENS-1:0]       switch_pos,
    output logic [NUM_SCREENS*SYM_W-1:0] screens,
    output logic [SYM_W-1:0]             main_display,
    output logic [1:0]                   checklight,
    output logic [3:0]                   stage,
    output logic [2:0]                   strikes,
    output logic [TIME_W-1:0]            time_left,
    output logic                         defused,
    output logic                         exploded
);

    localparam int          IDX_W    = $clog2(NUM_SCREENS);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_DEFUSED, S_EXPLODED} state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [15:0]                    r_lfsr;
    logic [15:0]                    w_lfsr_nxt;
    logic [NUM_SCREENS*SYM_W-1:0]   r_screens;
    logic [SYM_W-1:0]               r_main;
    logic [1:0]                     r_check;
    logic [3:0]                     r_stage;
    logic [2:0]                     r_strikes;
    logic [TIME_W-1:0]              r_time;

    logic [IDX_W-1:0]               w_idx;
    logic                           w_found;
    logic [NUM_SCREENS-1:0]         w_expect;
    logic                           w_correct;
    logic                           w_start;
    logic                           w_set;
    logic                           w_tick;
    logic                           w_time_zero;
    logic [3:0]                     w_stage_nxt;
    logic [2:0]                     w_strikes_nxt;

    // Galois form of x^16+x^14+x^13+x^11+1
    assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);

    always_comb begin
        w_idx   = IDX_W'(NUM_SCREENS - 1);
        w_found = 1'b0;
        for (int i = 0; i < NUM_SCREENS; i++) begin
            if (!w_found && (r_screens[i*SYM_W +: SYM_W] == r_main)) begin
                w_idx   = IDX_W'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_expect      = NUM_SCREENS'(1) << w_idx;
    assign w_correct     = (switch_pos == w_expect);
    assign w_start       = start_btn && ((r_state == S_IDLE) || (r_state == S_DEFUSED) ||
                                         (r_state == S_EXPLODED));
    assign w_set         = set_btn && (r_state == S_WAIT);
    assign w_tick        = tick && ((r_state == S_LOAD) || (r_state == S_WAIT)) &&
                           (r_time != '0);
    assign w_time_zero   = w_tick && (r_time == TIME_W'(1));
    assign w_stage_nxt   = r_stage + 4'd1;
    assign w_strikes_nxt = r_strikes + 3'd1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DEFUSED, S_EXPLODED: begin
                if (start_btn) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = w_time_zero ? S_EXPLODED : S_WAIT;
            end
            S_WAIT: begin
                // A winning final answer beats a timer expiring on the same edge
                if (w_set && w_correct && (w_stage_nxt == 4'(STAGES)))
                    w_state_nxt = S_DEFUSED;
                else if (w_time_zero)
                    w_state_nxt = S_EXPLODED;
                else if (w_set && !w_correct && (w_strikes_nxt == 3'(MAX_STRIKES)))
                    w_state_nxt = S_EXPLODED;
                else if (w_set && w_correct)
                    w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        defused  = 1'b0;
        exploded = 1'b0;
        case (r_state)
            S_DEFUSED:  defused  = 1'b1;
            S_EXPLODED: exploded = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_lfsr    <= SEED_EFF;
            r_screens <= '0;
            r_main    <= '0;
            r_check   <= 2'b00;
            r_stage   <= 4'd0;
            r_strikes <= 3'd0;
            r_time    <= '0;
        end else begin
            r_lfsr <= w_lfsr_nxt;
            if (w_start) begin
                r_check   <= 2'b00;
                r_stage   <= 4'd0;
                r_strikes <= 3'd0;
                r_time    <= TIME_W'(TIME_INIT);
            end
            if (r_state == S_LOAD) begin
                r_screens <= r_lfsr[NUM_SCREENS*SYM_W-1:0];
                r_main    <= r_lfsr[NUM_SCREENS*SYM_W +: SYM_W];
            end
            if (w_set) begin
                if (w_correct) begin
                    r_stage <= w_stage_nxt;
                    r_check <= 2'b01;
                end else begin
                    r_strikes <= w_strikes_nxt;
                    r_check   <= 2'b10;
                end
            end
            if (w_tick) r_time <= r_time - TIME_W'(1);
        end
    end

    assign screens      = r_screens;
    assign main_display = r_main;
    assign checklight   = r_check;
    assign stage        = r_stage;
    assign strikes      = r_strikes;
    assign time_left    = r_time;

endmodule

// File: tb/tb_defuse_game_core.sv
// tb/tb_defuse_game_core.sv - directed checks of defuse_game_core against an LFSR/answer model
module tb_defuse_game_core;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       tick = 1'b0, start_btn = 1'b0, set_btn = 1'b0;
    logic [3:0] switch_pos = 4'b0000;
    logic       tick2 = 1'b0, start2 = 1'b0, set2 = 1'b0;
    logic [3:0] sw2 = 4'b0000;

    logic [7:0] screens, screens2;
    logic [1:0] main_display, main2, checklight, check2;
    logic [3:0] stage, stage2;
    logic [2:0] strikes, strikes2;
    logic [7:0] time_left;
    logic [1:0] time2;
    logic       defused, exploded, defused2, exploded2;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] lfsr_m;
    logic [15:0] ld;
    logic [15:0] cur;
    logic [9:0]  first_p;

    defuse_game_core dut (
        .CLK(CLK), .RST(RST), .tick(tick), .start_btn(start_btn), .set_btn(set_btn),
        .switch_pos(switch_pos), .screens(screens), .main_display(main_display),
        .checklight(checklight), .stage(stage), .strikes(strikes), .time_left(time_left),
        .defused(defused), .exploded(exploded)
    );

    defuse_game_core #(.STAGES(1), .TIME_W(2), .TIME_INIT(2)) dut2 (
        .CLK(CLK), .RST(RST), .tick(tick2), .start_btn(start2), .set_btn(set2),
        .switch_pos(sw2), .screens(screens2), .main_display(main2),
        .checklight(check2), .stage(stage2), .strikes(strikes2), .time_left(time2),
        .defused(defused2), .exploded(exploded2)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] nx(input logic [15:0] v);
        nx = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Lowest screen matching main, else the last screen
    function automatic int cidx(input logic [15:0] p);
        cidx = 3;
        for (int i = 3; i >= 0; i--)
            if (p[2*i +: 2] == p[9:8]) cidx = i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        if (RST) lfsr_m = nx(lfsr_m);
        @(negedge CLK);
    endtask

    task automatic seek(input logic [9:0] tgt);
        logic [15:0] t;
        logic        hit;
        hit = 1'b0;
        for (int k = 0; k < 20000 && !hit; k++) begin
            t = nx(lfsr_m);
            if (t[9:0] == tgt) hit = 1'b1;
            else step();
        end
        chk("seek", {31'd0, hit}, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_scr"}, {24'd0, screens}, 32'd0);
        chk({tag, "_main"}, {30'd0, main_display}, 32'd0);
        chk({tag, "_chk"}, {30'd0, checklight}, 32'd0);
        chk({tag, "_stage"}, {28'd0, stage}, 32'd0);
        chk({tag, "_strk"}, {29'd0, strikes}, 32'd0);
        chk({tag, "_time"}, {24'd0, time_left}, 32'd0);
        chk({tag, "_def"}, {31'd0, defused}, 32'd0);
        chk({tag, "_exp"}, {31'd0, exploded}, 32'd0);
    endtask

    task automatic answer(input logic [3:0] sw);
        switch_pos = sw;
        set_btn = 1'b1;
        step();
        set_btn = 1'b0;
    endtask

    initial begin
        lfsr_m = 16'hACE1;
        repeat (2) @(negedge CLK);
        chk_reset("rst");
        chk("rst_time2", {30'd0, time2}, 32'd0);

        // First game: puzzle straight from the fresh-reset sequence
        RST = 1'b1;
        step(); step();
        ld = nx(lfsr_m);
        start_btn = 1'b1; step(); start_btn = 1'b0;
        step();
        first_p = ld[9:0];
        cur = ld;
        chk("g1_time", {24'd0, time_left}, 32'd60);
        chk("g1_stage", {28'd0, stage}, 32'd0);
        chk("g1_scr", {24'd0, screens}, {24'd0, ld[7:0]});
        chk("g1_main", {30'd0, main_display}, {30'd0, ld[9:8]});
        chk("g1_exp", {31'd0, exploded}, 32'd0);

        // Correct answer timed so the next puzzle is screens {0,2,2,1}, main 2
        seek(10'h268);
        ld = nx(lfsr_m);
        answer(4'(1 << cidx(cur)));
        chk("c1_chk", {30'd0, checklight}, 32'd1);
        chk("c1_stage", {28'd0, stage}, 32'd1);
        step();
        cur = ld;
        chk("pa_scr", {24'd0, screens}, 32'h68);
        chk("pa_main", {30'd0, main_display}, 32'd2);

        answer(4'b0100);
        chk("pa_wr_chk", {30'd0, checklight}, 32'd2);
        chk("pa_wr_strk", {29'd0, strikes}, 32'd1);
        chk("pa_wr_scr", {24'd0, screens}, 32'h68);

        // Correct 0010 while the no-match puzzle {0,0,1,1}, main 3 is drawn
        seek(10'h350);
        answer(4'b0010);
        chk("pa_ok_chk", {30'd0, checklight}, 32'd1);
        chk("pa_ok_stage", {28'd0, stage}, 32'd2);
        step();
        chk("pb_scr", {24'd0, screens}, 32'h50);
        chk("pb_main", {30'd0, main_display}, 32'd3);

        answer(4'b1100);
        chk("pb_multi_strk", {29'd0, strikes}, 32'd2);
        chk("pb_multi_exp", {31'd0, exploded}, 32'd0);
        answer(4'b0000);
        chk("pb_zero_strk", {29'd0, strikes}, 32'd3);
        chk("pb_zero_exp", {31'd0, exploded}, 32'd1);

        // Terminal state ignores set and tick
        switch_pos = 4'b1000; set_btn = 1'b1; tick = 1'b1;
        step();
        set_btn = 1'b0; tick = 1'b0;
        chk("frz_strk", {29'd0, strikes}, 32'd3);
        chk("frz_stage", {28'd0, stage}, 32'd2);
        chk("frz_chk", {30'd0, checklight}, 32'd2);
        chk("frz_time", {24'd0, time_left}, 32'd60);
        chk("frz_exp", {31'd0, exploded}, 32'd1);

        // Restart from EXPLODED straight into the no-match puzzle
        seek(10'h350);
        start_btn = 1'b1; step(); start_btn = 1'b0;
        chk("rs_strk", {29'd0, strikes}, 32'd0);
        chk("rs_chk", {30'd0, checklight}, 32'd0);
        chk("rs_exp", {31'd0, exploded}, 32'd0);
        step();
        chk("rs_scr", {24'd0, screens}, 32'h50);
        ld = nx(lfsr_m);
        answer(4'b1000);
        chk("pb_ok_chk", {30'd0, checklight}, 32'd1);
        chk("pb_ok_stage", {28'd0, stage}, 32'd1);
        step();
        cur = ld;
        answer(4'(1 << cidx(cur)));
        chk("s2_stage", {28'd0, stage}, 32'd2);
        step();

        // Asynchronous reset mid-game
        RST = 1'b0;
        #1;
        chk_reset("arst");
        lfsr_m = 16'hACE1;
        @(negedge CLK);
        RST = 1'b1;
        step(); step();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        step();
        chk("rr_scr", {24'd0, screens}, {24'd0, first_p[7:0]});
        chk("rr_main", {30'd0, main_display}, {30'd0, first_p[9:8]});

        // Short-timer instance: timeout explosion
        start2 = 1'b1; step(); start2 = 1'b0;
        step();
        chk("t_init", {30'd0, time2}, 32'd2);
        tick2 = 1'b1; step(); tick2 = 1'b0;
        chk("t_one", {30'd0, time2}, 32'd1);
        chk("t_one_exp", {31'd0, exploded2}, 32'd0);
        tick2 = 1'b1; step(); tick2 = 1'b0;
        chk("t_zero", {30'd0, time2}, 32'd0);
        chk("t_zero_exp", {31'd0, exploded2}, 32'd1);

        // Final correct answer on the zeroing tick defuses
        ld = nx(lfsr_m);
        start2 = 1'b1; step(); start2 = 1'b0;
        step();
        cur = ld;
        tick2 = 1'b1; step(); tick2 = 1'b0;
        sw2 = 4'(1 << cidx(cur));
        set2 = 1'b1; tick2 = 1'b1;
        step();
        set2 = 1'b0; tick2 = 1'b0;
        chk("race_def", {31'd0, defused2}, 32'd1);
        chk("race_exp", {31'd0, exploded2}, 32'd0);
        chk("race_stage", {28'd0, stage2}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
